// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - HDMI/DVI period scheduler: raster counters, video and data-island periods
// Data islands are built only with HDMI_DATA_ISLAND_EN defined; otherwise the block is a DVI-only scheduler.
module hdmi_period_scheduler #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        packet_pending,
  input  logic [8:0]  packet_word,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic [2:0]  mode,
  output logic [5:0]  control_data,
  output logic [11:0] data_island_data,
  output logic [4:0]  packet_idx,
  output logic        packet_consume,
  output logic        video_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] X_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] X_HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] X_HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] X_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] X_VPRE     = 12'(H_TOTAL - 10);
  localparam logic [11:0] X_VPRE_END = 12'(H_TOTAL - 3);
  localparam logic [11:0] X_VGUARD   = 12'(H_TOTAL - 2);
  localparam logic [11:0] X_DECIDE   = 12'(H_ACTIVE + 3);
  localparam logic [11:0] X_IPRE     = 12'(H_ACTIVE + 4);
  localparam logic [11:0] X_IPRE_END = 12'(H_ACTIVE + 11);
  localparam logic [11:0] X_IG1      = 12'(H_ACTIVE + 12);
  localparam logic [11:0] X_IG1_END  = 12'(H_ACTIVE + 13);
  localparam logic [11:0] X_PKT      = 12'(H_ACTIVE + 14);
  localparam logic [11:0] X_PKT_END  = 12'(H_ACTIVE + 45);
  localparam logic [11:0] X_IG2      = 12'(H_ACTIVE + 46);
  localparam logic [11:0] X_IG2_END  = 12'(H_ACTIVE + 47);

  localparam logic [10:0] Y_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] Y_VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] Y_VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [10:0] Y_LAST     = 11'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_IGUARD = 3'd4
  } mode_t;

  logic [11:0] cx_next;
  logic [10:0] cy_next;
  logic [10:0] cy_plus1;
  logic        hsync;
  logic        vsync;
  logic        video_line;
  logic        video_pre_line;
  logic        island_line;

  always_comb begin
    cy_plus1 = (cy == Y_LAST) ? 11'd0 : cy + 11'd1;
    cx_next  = cx + 12'd1;
    cy_next  = cy;
    if (cx == X_LAST) begin
      cx_next = 12'd0;
      cy_next = cy_plus1;
    end
  end

  assign hsync          = (cx >= X_HS_START && cx < X_HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync          = (cy >= Y_VS_START && cy < Y_VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign video_line     = (cy < Y_ACT);
  assign video_pre_line = video_line || (cy_plus1 < Y_ACT);

`ifdef HDMI_DATA_ISLAND_EN
  // One decision per line; the flag holds through the whole island window.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      island_line <= 1'b0;
    end else if (cx == X_DECIDE) begin
      island_line <= packet_pending;
    end
  end
`else
  logic unused_pending;
  assign unused_pending = packet_pending;
  assign island_line    = 1'b0;
`endif

  mode_t       mode_d;
  logic [3:0]  ctl_hi_d;
  logic [11:0] isl_data_d;
  logic        first_n;
  logic        consume_d;
  logic [4:0]  idx_d;
  logic        va_d;

  always_comb begin
    mode_d     = MODE_CTRL;
    ctl_hi_d   = 4'b0000;
    isl_data_d = 12'd0;
    first_n    = (cx != X_PKT);
    if (video_line && cx < X_ACT) begin
      mode_d = MODE_VIDEO;
    end else if (video_pre_line && cx >= X_VPRE && cx <= X_VPRE_END) begin
      ctl_hi_d = 4'b0001;
    end else if (video_pre_line && cx >= X_VGUARD) begin
      mode_d = MODE_VGUARD;
    end else if (island_line) begin
      if (cx >= X_IPRE && cx <= X_IPRE_END) begin
        ctl_hi_d = 4'b0101;
      end else if ((cx >= X_IG1 && cx <= X_IG1_END) || (cx >= X_IG2 && cx <= X_IG2_END)) begin
        mode_d = MODE_IGUARD;
      end else if (cx >= X_PKT && cx <= X_PKT_END) begin
        mode_d     = MODE_ISLAND;
        isl_data_d = {packet_word[8:5], packet_word[4:1], first_n, packet_word[0], vsync, hsync};
      end
    end
  end

  // Index/consume and video_active look one pixel ahead so packet_word is valid
  // in the cycle whose island data gets registered.
  always_comb begin
    consume_d = island_line && (cx_next >= X_PKT) && (cx_next <= X_PKT_END);
    idx_d     = consume_d ? 5'(cx_next - X_PKT) : 5'd0;
    va_d      = (cy_next < Y_ACT) && (cx_next < X_ACT);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx               <= X_ACT;
      cy               <= Y_ACT;
      mode             <= MODE_CTRL;
      control_data     <= {4'b0000, ~SYNC_ACTIVE, ~SYNC_ACTIVE};
      data_island_data <= 12'd0;
      packet_idx       <= 5'd0;
      packet_consume   <= 1'b0;
      video_active     <= 1'b0;
    end else begin
      cx               <= cx_next;
      cy               <= cy_next;
      mode             <= mode_d;
      control_data     <= {ctl_hi_d, vsync, hsync};
      data_island_data <= isl_data_d;
      packet_idx       <= idx_d;
      packet_consume   <= consume_d;
      video_active     <= va_d;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - self-checking bench for hdmi_period_scheduler
`timescale 1ns/1ps
module tb_hdmi_period_scheduler;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 12, VF = 3, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic SA = 1'b0;
`ifdef HDMI_DATA_ISLAND_EN
  localparam bit ISL_EN = 1'b1;
`else
  localparam bit ISL_EN = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        packet_pending = 1'b0;
  logic [8:0]  packet_word;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [2:0]  mode;
  logic [5:0]  control_data;
  logic [11:0] data_island_data;
  logic [4:0]  packet_idx;
  logic        packet_consume;
  logic        video_active;

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .packet_pending(packet_pending),
    .packet_word(packet_word),
    .cx(cx),
    .cy(cy),
    .mode(mode),
    .control_data(control_data),
    .data_island_data(data_island_data),
    .packet_idx(packet_idx),
    .packet_consume(packet_consume),
    .video_active(video_active)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [8:0] pat(input int i);
    return 9'((i * 53 + 17) % 512);
  endfunction

  assign packet_word = pat(int'(packet_idx));

  int passed = 0;
  int total = 0;

  // Model raster position, island flag for the current line, and the previous cycle's position.
  int mx, my, px, py;
  bit isl, pisl;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d)", name, act, exp, mx, my);
  endtask

  always @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mx = HA; my = VA; isl = 1'b0; pisl = 1'b0; px = HA; py = VA;
    end else begin
      if (ISL_EN && mx == HA + 3) isl = packet_pending;
      px = mx; py = my; pisl = isl;
      mx++;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end
  end

  function automatic logic hs_f(input int x);
    return (x >= HA + HF && x < HA + HF + HS) ? SA : ~SA;
  endfunction

  function automatic logic vs_f(input int y);
    return (y >= VA + VF && y < VA + VF + VS) ? SA : ~SA;
  endfunction

  function automatic void expect_at(input int x, input int y, input bit il,
                                    output logic [2:0] m, output logic [3:0] hi,
                                    output logic [11:0] d);
    bit cur_act, nxt_act;
    int off;
    logic [8:0] w;
    cur_act = (y < VA);
    nxt_act = (((y + 1) % VT) < VA);
    off = x - HA;
    w = pat(off - 14);
    m = 3'd0; hi = 4'b0000; d = 12'd0;
    if (cur_act && x < HA) m = 3'd1;
    else if ((cur_act || nxt_act) && x >= HT - 10 && x <= HT - 3) hi = 4'b0001;
    else if ((cur_act || nxt_act) && x >= HT - 2) m = 3'd2;
    else if (il) begin
      if (off >= 4 && off <= 11) hi = 4'b0101;
      else if (off == 12 || off == 13 || off == 46 || off == 47) m = 3'd4;
      else if (off >= 14 && off <= 45) begin
        m = 3'd3;
        d = {w[8:5], w[4:1], (off != 14), w[0], vs_f(y), hs_f(x)};
      end
    end
  endfunction

  logic [2:0] hist_mode [10];
  logic [5:0] hist_ctl [10];
  logic [2:0] last_mode = 3'd0;
  int run_len = 0;
  int runs = 0;

  initial begin
    logic [2:0]  em;
    logic [3:0]  ehi;
    logic [11:0] ed;
    bit          in_pkt;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (reset) begin
        check("rst_cx", cx, HA);
        check("rst_cy", cy, VA);
        check("rst_mode", mode, 0);
        check("rst_ctl", control_data, {4'b0000, ~SA, ~SA});
        check("rst_did", data_island_data, 0);
        check("rst_idx", packet_idx, 0);
        check("rst_consume", packet_consume, 0);
        check("rst_va", video_active, 0);
        last_mode = 3'd0;
      end else begin
        expect_at(px, py, pisl, em, ehi, ed);
        in_pkt = isl && mx >= HA + 14 && mx <= HA + 45;
        check("cx", cx, mx);
        check("cy", cy, my);
        check("mode", mode, em);
        check("control_data", control_data, {ehi, vs_f(py), hs_f(px)});
        check("data_island_data", data_island_data, ed);
        check("packet_consume", packet_consume, in_pkt);
        check("packet_idx", packet_idx, in_pkt ? mx - (HA + 14) : 0);
        check("video_active", video_active, (my < VA) && (mx < HA));
        if (mode == 3'd1) begin
          if (last_mode != 3'd1) begin
            run_len = 0;
            runs++;
            check("vid_guard", {hist_mode[0], hist_mode[1]}, {3'd2, 3'd2});
            for (int k = 2; k < 10; k++)
              check("vid_preamble", {hist_mode[k], hist_ctl[k][5:2]}, {3'd0, 4'b0001});
          end
          run_len++;
        end else if (last_mode == 3'd1) begin
          check("vid_run_len", run_len, HA);
        end
        last_mode = mode;
      end
      for (int k = 9; k > 0; k--) begin
        hist_mode[k] = hist_mode[k-1];
        hist_ctl[k]  = hist_ctl[k-1];
      end
      hist_mode[0] = mode;
      hist_ctl[0]  = control_data;
    end
  end

  task automatic wait_pos(input int x, input int y);
    int n;
    n = 0;
    while (!(mx == x && my == y) && n < 2 * HT * VT) begin
      @(negedge clk_pixel);
      n++;
    end
    check("wait_pos_reached", (mx == x && my == y), 1);
  endtask

  initial begin
    int cons, m3, n;
    reset = 1'b1;
    packet_pending = 1'b0;
    repeat (3) @(negedge clk_pixel);
    reset = 1'b0;

    // Two plain frames: every active line is one 640-pixel video run.
    repeat (2 * HT * VT) @(negedge clk_pixel);
    check("two_frame_video_lines", runs, 2 * VA);

    // Pending held for all of line 5.
    wait_pos(0, 5);
    packet_pending = 1'b1;
    wait_pos(HA + 14, 5);
    check("l5_idx_first", packet_idx, 0);
    check("l5_consume_first", packet_consume, ISL_EN ? 1 : 0);
    check("l5_mode_653", mode, ISL_EN ? 4 : 0);
    wait_pos(HA + 15, 5);
    check("l5_mode_654", mode, ISL_EN ? 3 : 0);
    check("l5_first_n_654", data_island_data[3], 0);
    check("l5_idx_655", packet_idx, ISL_EN ? 1 : 0);
    wait_pos(HA + 16, 5);
    check("l5_first_n_655", data_island_data[3], ISL_EN ? 1 : 0);
    wait_pos(HA + 45, 5);
    check("l5_idx_last", packet_idx, ISL_EN ? 31 : 0);
    wait_pos(HA + 47, 5);
    check("l5_mode_686", mode, ISL_EN ? 4 : 0);
    check("l5_consume_after", packet_consume, 0);
    wait_pos(0, 6);
    packet_pending = 1'b0;

    // Pulse from cx 643 to cx 660 on line 8: full island, nothing on line 9.
    wait_pos(HA + 3, 8);
    packet_pending = 1'b1;
    cons = 0; m3 = 0; n = 0;
    while (!(mx == 0 && my == 9) && n < HT) begin
      if (mx == HA + 20) packet_pending = 1'b0;
      cons += int'(packet_consume);
      m3 += int'(mode == 3'd3);
      @(negedge clk_pixel);
      n++;
    end
    check("pulse_words", cons, ISL_EN ? 32 : 0);
    check("pulse_mode3", m3, ISL_EN ? 32 : 0);
    cons = 0; m3 = 0;
    for (int i = 0; i < HT; i++) begin
      cons += int'(packet_consume);
      m3 += int'(mode == 3'd3 || mode == 3'd4);
      @(negedge clk_pixel);
    end
    check("next_line_words", cons, 0);
    check("next_line_island", m3, 0);

    // Island on the first vsync line.
    wait_pos(0, VA + VF);
    packet_pending = 1'b1;
    wait_pos(HA + 13, VA + VF);
    check("vs_guard_mode", mode, ISL_EN ? 4 : 0);
    check("vs_guard_ch0", control_data[1:0], {SA, ~SA});
    packet_pending = 1'b0;
    wait_pos(HA + 21, VA + VF);
    check("vs_pkt_vsync_bit", data_island_data[1], ISL_EN ? SA : 1'b0);
    check("vs_pkt_hsync_bit", data_island_data[0], ISL_EN ? SA : 1'b0);
    wait_pos(HA + 47, VA + VF);
    check("vs_tguard_ch0", control_data[1:0], {SA, SA});

    // Reset mid-island at cx 670.
    wait_pos(0, 3);
    packet_pending = 1'b1;
    wait_pos(HA + 30, 3);
    check("pre_reset_mode", mode, ISL_EN ? 3 : 0);
    reset = 1'b1;
    packet_pending = 1'b0;
    #1;
    check("reset_mode", mode, 0);
    check("reset_consume", packet_consume, 0);
    @(negedge clk_pixel);
    reset = 1'b0;
    check("release_cx", cx, HA);
    check("release_cy", cy, VA);
    wait_pos(0, VA + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
